// File: rtl/mem_access_unit.sv
// RV32 load/store unit for the MEM stage: byte/halfword/word accesses mapped onto a
// word-wide Data_Memory port, sub-word stores via read-modify-write. Option: MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  input  logic              REQ_WRITE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              STALL,
  output logic              RESP_VALID,
  output logic [31:0]       RESP_RDATA,
  output logic              MISALIGNED,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WRITEENABLE,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_RMW_MERGE = 2'd2,
    S_RMW_WRITE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] merge_r;

  logic        load_ok_s;
  logic        store_ok_s;
  logic        op_ok_s;
  logic        sub_store_s;
  logic        misalign_s;
  logic        accept_s;

  // Select and extend the addressed lane of a read word.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      3'b010:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Replace the addressed byte or halfword of the old word with store data.
  function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] res;
    res = old;
    case (f3)
      3'b000: res[{off, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (off[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      default: res = old;
    endcase
    return res;
  endfunction

  // Request decode; inputs are held stable by the pipeline, so decode is valid in every state.
  always_comb begin
    load_ok_s  = 1'b0;
    store_ok_s = 1'b0;
    case (REQ_FUNCT3)
      3'b000, 3'b001, 3'b010: begin
        load_ok_s  = 1'b1;
        store_ok_s = 1'b1;
      end
      3'b100, 3'b101: begin
        load_ok_s  = 1'b1;
        store_ok_s = 1'b0;
      end
      default: begin
        load_ok_s  = 1'b0;
        store_ok_s = 1'b0;
      end
    endcase
    op_ok_s     = REQ_WRITE ? store_ok_s : load_ok_s;
    sub_store_s = REQ_WRITE && store_ok_s && !REQ_FUNCT3[1];
`ifdef MISALIGN_TRAP_EN
    misalign_s = REQ_VALID && op_ok_s &&
                 (((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                  ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00)));
`else
    misalign_s = 1'b0;
`endif
    accept_s = (state_r == S_IDLE) && REQ_VALID && op_ok_s && !misalign_s;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (accept_s && !REQ_WRITE) begin
          state_next_s = S_LOAD_WAIT;
        end else if (accept_s && sub_store_s) begin
          state_next_s = S_RMW_MERGE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD_WAIT: state_next_s = S_IDLE;
      S_RMW_MERGE: state_next_s = S_RMW_WRITE;
      S_RMW_WRITE: state_next_s = S_IDLE;
      default:     state_next_s = S_IDLE;
    endcase
  end

  // Merge register: read word with the store lane(s) replaced, captured in RMW_MERGE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      merge_r <= 32'd0;
    end else if (state_r == S_RMW_MERGE) begin
      merge_r <= merge_store(REQ_FUNCT3, REQ_ADDR[1:0], MEM_RDATA, REQ_WDATA);
    end else begin
      merge_r <= merge_r;
    end
  end

  // Output decode; every strobe is forced low while RESET is high.
  always_comb begin
    STALL           = 1'b0;
    RESP_VALID      = 1'b0;
    RESP_RDATA      = 32'd0;
    MISALIGNED      = 1'b0;
    MEM_WRITEENABLE = 1'b0;
    MEM_WDATA       = REQ_WDATA;
    MEM_ADDR        = {REQ_ADDR[ADDR_W-1:2], 2'b00};
    if (RESET) begin
      STALL = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          MISALIGNED = misalign_s;
          if (accept_s && REQ_WRITE && !sub_store_s) begin
            MEM_WRITEENABLE = 1'b1;
          end else if (accept_s) begin
            STALL = 1'b1;
          end else begin
            STALL = 1'b0;
          end
        end
        S_LOAD_WAIT: begin
          RESP_VALID = 1'b1;
          RESP_RDATA = extend_load(REQ_FUNCT3, REQ_ADDR[1:0], MEM_RDATA);
        end
        S_RMW_MERGE: STALL = 1'b1;
        S_RMW_WRITE: begin
          MEM_WRITEENABLE = 1'b1;
          MEM_WDATA       = merge_r;
        end
        default: STALL = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed spec vectors plus random traffic against a
// byte-addressed reference model. Honours MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_WRITE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        STALL;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic        MISALIGNED;
  logic [31:0] MEM_ADDR;
  logic        MEM_WRITEENABLE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;

  int total = 0;
  int bad = 0;
  int wr_count = 0;

  logic [31:0] mem [0:255];
  logic [7:0]  mb [0:1023];

  int          obs_stall, obs_wr, obs_resp, obs_mis;
  logic [31:0] obs_wdata, obs_rdata;
  logic        obs_done, obs_zero_bad, obs_addr_bad;

  mem_access_unit #(.ADDR_W(32)) dut (
    .CLK(clk), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .STALL(STALL), .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA),
    .MISALIGNED(MISALIGNED), .MEM_ADDR(MEM_ADDR), .MEM_WRITEENABLE(MEM_WRITEENABLE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 clk = ~clk;

  // Data_Memory with registered read
  always @(posedge clk) begin
    if (MEM_WRITEENABLE === 1'b1) begin
      mem[MEM_ADDR[9:2]] <= MEM_WDATA;
      wr_count <= wr_count + 1;
    end
    MEM_RDATA <= mem[MEM_ADDR[9:2]];
  end

  // ---------------- reference model ----------------
  function automatic logic m_valid(input logic w, input logic [2:0] f3);
    if (w) return (f3 <= 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic logic m_mis(input logic w, input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    int size;
    size = 1 << f3[1:0];
    return m_valid(w, f3) && ((int'(a[9:0]) % size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int i;
    i = int'(a[9:0]) & ~3;
    return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int i;
    logic signed [31:0] s;
    i = int'(a[9:0]);
    case (f3)
      3'd0: begin s = $signed(mb[i]); return s; end
      3'd1: begin i = i & ~1; s = $signed({mb[i+1], mb[i]}); return s; end
      3'd2: return m_word(a);
      3'd4: return {24'd0, mb[i]};
      3'd5: begin i = i & ~1; return {16'd0, mb[i+1], mb[i]}; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a[9:0]);
    case (f3)
      3'd0: mb[i] = d[7:0];
      3'd1: begin i = i & ~1; mb[i] = d[7:0]; mb[i+1] = d[15:8]; end
      default: begin
        i = i & ~3;
        mb[i] = d[7:0]; mb[i+1] = d[15:8]; mb[i+2] = d[23:16]; mb[i+3] = d[31:24];
      end
    endcase
  endtask

  // Drive one request until STALL is low; entered and left #1 after a rising edge.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = d;
    obs_stall = 0; obs_wr = 0; obs_resp = 0; obs_mis = 0;
    obs_wdata = 32'd0; obs_rdata = 32'd0;
    obs_done = 1'b0; obs_zero_bad = 1'b0; obs_addr_bad = 1'b0;
    for (int c = 0; c < 8 && !obs_done; c++) begin
      @(negedge clk);
      if (MEM_ADDR !== {a[31:2], 2'b00}) obs_addr_bad = 1'b1;
      if (MEM_WRITEENABLE === 1'b1) begin obs_wr++; obs_wdata = MEM_WDATA; end
      if (RESP_VALID === 1'b1) begin obs_resp++; obs_rdata = RESP_RDATA; end
      else if (RESP_RDATA !== 32'd0) obs_zero_bad = 1'b1;
      if (MISALIGNED === 1'b1) obs_mis++;
      if (STALL === 1'b0) obs_done = 1'b1;
      else obs_stall++;
      @(posedge clk); #1;
    end
    REQ_VALID = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1; REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_FUNCT3 = 3'd2;
    REQ_ADDR = 32'h41; REQ_WDATA = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({STALL, RESP_VALID, MEM_WRITEENABLE, MISALIGNED} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=0000", {STALL, RESP_VALID, MEM_WRITEENABLE, MISALIGNED});
    end
    total++;
    if (RESP_RDATA !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", RESP_RDATA); end
    @(posedge clk); #1;
    RESET = 1'b0; REQ_VALID = 1'b0;
    @(negedge clk);
    total++;
    if ({STALL, RESP_VALID, MEM_WRITEENABLE, MISALIGNED} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_strobes got=%b want=0000", {STALL, RESP_VALID, MEM_WRITEENABLE, MISALIGNED});
    end
    @(posedge clk); #1;
    total++;
    if (wr_count !== 0) begin bad++; $display("FAIL reset_no_write got=%0d want=0", wr_count); end
    // Fill the 32 test words through the unit so memory and model agree.
    for (int k = 0; k < 32; k++) begin
      logic [31:0] d;
      d = $urandom;
      run_req(1'b1, 3'd2, 32'(k * 4), d);
      m_store(3'd2, 32'(k * 4), d);
    end
    total++;
    if (wr_count !== 32) begin bad++; $display("FAIL fill_writes got=%0d want=32", wr_count); end
  endtask

  typedef struct { logic w; logic [2:0] f3; logic [31:0] a; logic [31:0] d; logic [31:0] ev; } vec_t;

  task automatic test_directed();
    vec_t v [10];
    int exp_stall;
    v[0] = '{1'b1, 3'd2, 32'h40, 32'h8000_1234, 32'h8000_1234};
    v[1] = '{1'b0, 3'd2, 32'h40, 32'h0, 32'h8000_1234};
    v[2] = '{1'b0, 3'd0, 32'h43, 32'h0, 32'hFFFF_FF80};
    v[3] = '{1'b0, 3'd4, 32'h43, 32'h0, 32'h0000_0080};
    v[4] = '{1'b0, 3'd1, 32'h40, 32'h0, 32'h0000_1234};
    v[5] = '{1'b0, 3'd5, 32'h42, 32'h0, 32'h0000_8000};
    v[6] = '{1'b1, 3'd2, 32'h50, 32'h1122_3344, 32'h1122_3344};
    v[7] = '{1'b1, 3'd0, 32'h51, 32'h0000_00AA, 32'h1122_AA44};
    v[8] = '{1'b1, 3'd1, 32'h52, 32'h0000_BEEF, 32'hBEEF_AA44};
    v[9] = '{1'b0, 3'd2, 32'h50, 32'h0, 32'hBEEF_AA44};
    for (int k = 0; k < 10; k++) begin
      exp_stall = !v[k].w ? 1 : (v[k].f3 == 3'd2 ? 0 : 2);
      run_req(v[k].w, v[k].f3, v[k].a, v[k].d);
      if (v[k].w) m_store(v[k].f3, v[k].a, v[k].d);
      total++;
      if (!obs_done) begin bad++; $display("FAIL dir%0d timeout", k); end
      total++;
      if (obs_stall !== exp_stall) begin bad++; $display("FAIL dir%0d stall got=%0d want=%0d", k, obs_stall, exp_stall); end
      total++;
      if (obs_wr !== int'(v[k].w)) begin bad++; $display("FAIL dir%0d writes got=%0d want=%0d", k, obs_wr, v[k].w); end
      total++;
      if (obs_resp !== int'(!v[k].w)) begin bad++; $display("FAIL dir%0d resp got=%0d want=%0d", k, obs_resp, !v[k].w); end
      total++;
      if ((v[k].w ? obs_wdata : obs_rdata) !== v[k].ev) begin
        bad++; $display("FAIL dir%0d data got=%h want=%h", k, v[k].w ? obs_wdata : obs_rdata, v[k].ev);
      end
      total++;
      if (obs_zero_bad || obs_addr_bad) begin bad++; $display("FAIL dir%0d rdata_zero/addr got=%b%b want=00", k, obs_zero_bad, obs_addr_bad); end
    end
  endtask

  task automatic test_reset_abort();
    int wc0;
    run_req(1'b1, 3'd2, 32'h50, 32'h1122_3344);
    m_store(3'd2, 32'h50, 32'h1122_3344);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_FUNCT3 = 3'd0; REQ_ADDR = 32'h50; REQ_WDATA = 32'h55;
    @(posedge clk); #1;
    RESET = 1'b1; REQ_VALID = 1'b0;
    wc0 = wr_count;
    @(negedge clk);
    total++;
    if ({STALL, RESP_VALID, MEM_WRITEENABLE, MISALIGNED} !== 4'b0000 || RESP_RDATA !== 32'd0) begin
      bad++; $display("FAIL abort_in_reset got=%b/%h want=0000/0", {STALL, RESP_VALID, MEM_WRITEENABLE, MISALIGNED}, RESP_RDATA);
    end
    @(posedge clk); #1;
    RESET = 1'b0;
    @(negedge clk);
    total++;
    if ({STALL, RESP_VALID, MEM_WRITEENABLE} !== 3'b000) begin
      bad++; $display("FAIL abort_after got=%b want=000", {STALL, RESP_VALID, MEM_WRITEENABLE});
    end
    @(posedge clk); #1;
    total++;
    if (wr_count !== wc0) begin bad++; $display("FAIL abort_no_write got=%0d want=%0d", wr_count, wc0); end
    run_req(1'b0, 3'd2, 32'h50, 32'h0);
    total++;
    if (obs_stall !== 1 || obs_rdata !== 32'h1122_3344) begin
      bad++; $display("FAIL abort_word got=%0d/%h want=1/11223344", obs_stall, obs_rdata);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] ev;
    logic        mis;
`ifdef MISALIGN_TRAP_EN
    mis = 1'b1;
`else
    mis = 1'b0;
`endif
    ev = m_word(32'h40);
    run_req(1'b0, 3'd2, 32'h41, 32'h0);
    total++;
    if (obs_mis !== int'(mis)) begin bad++; $display("FAIL mis_flag got=%0d want=%0d", obs_mis, mis); end
    total++;
    if (obs_resp !== int'(!mis) || obs_stall !== int'(!mis)) begin
      bad++; $display("FAIL mis_lw resp/stall got=%0d/%0d want=%0d/%0d", obs_resp, obs_stall, !mis, !mis);
    end
    total++;
    if (!mis && obs_rdata !== ev) begin bad++; $display("FAIL mis_lw_data got=%h want=%h", obs_rdata, ev); end
    run_req(1'b1, 3'd1, 32'h45, 32'h0000_CAFE);
    if (!mis) m_store(3'd1, 32'h45, 32'h0000_CAFE);
    total++;
    if (obs_wr !== int'(!mis) || obs_mis !== int'(mis)) begin
      bad++; $display("FAIL mis_sh wr/mis got=%0d/%0d want=%0d/%0d", obs_wr, obs_mis, !mis, mis);
    end
    run_req(1'b0, 3'd2, 32'h44, 32'h0);
    total++;
    if (obs_rdata !== m_word(32'h44)) begin bad++; $display("FAIL mis_sh_word got=%h want=%h", obs_rdata, m_word(32'h44)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] ev;
    d = $urandom;
    ev = m_load(3'd2, 32'h40);
    run_req(1'b0, 3'd2, 32'h40, 32'h0);
    total++;
    if (obs_resp !== 1 || obs_rdata !== ev) begin bad++; $display("FAIL b2b_load got=%0d/%h want=1/%h", obs_resp, obs_rdata, ev); end
    run_req(1'b1, 3'd2, 32'h44, d);
    m_store(3'd2, 32'h44, d);
    total++;
    if (obs_stall !== 0 || obs_wr !== 1 || obs_wdata !== d) begin
      bad++; $display("FAIL b2b_sw got=%0d/%0d/%h want=0/1/%h", obs_stall, obs_wr, obs_wdata, d);
    end
    run_req(1'b0, 3'd2, 32'h44, 32'h0);
    total++;
    if (obs_rdata !== d) begin bad++; $display("FAIL b2b_readback got=%h want=%h", obs_rdata, d); end
  endtask

  task automatic test_random();
    logic        w, mis, ok;
    logic [2:0]  f3;
    logic [31:0] a, d, ev;
    int          exp_stall, exp_wr, exp_resp;
    for (int k = 0; k < 300; k++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 127));
      d = $urandom;
      ok = m_valid(w, f3);
      mis = m_mis(w, f3, a);
      exp_wr = (w && ok && !mis) ? 1 : 0;
      exp_resp = (!w && ok && !mis) ? 1 : 0;
      exp_stall = exp_resp ? 1 : ((exp_wr != 0 && f3 != 3'd2) ? 2 : 0);
      ev = m_load(f3, a);
      run_req(w, f3, a, d);
      if (exp_wr != 0) begin
        m_store(f3, a, d);
        ev = m_word(a);
      end
      total++;
      if (!obs_done || obs_stall !== exp_stall) begin
        bad++; $display("FAIL rnd%0d stall w=%0d f3=%0d a=%h got=%0d want=%0d", k, w, f3, a, obs_stall, exp_stall);
      end
      total++;
      if (obs_wr !== exp_wr || obs_resp !== exp_resp || obs_mis !== int'(mis)) begin
        bad++; $display("FAIL rnd%0d wr/resp/mis got=%0d%0d%0d want=%0d%0d%0d", k, obs_wr, obs_resp, obs_mis, exp_wr, exp_resp, mis);
      end
      total++;
      if ((exp_wr != 0 && obs_wdata !== ev) || (exp_resp != 0 && obs_rdata !== ev)) begin
        bad++; $display("FAIL rnd%0d data w=%0d f3=%0d a=%h got=%h want=%h", k, w, f3, a, w ? obs_wdata : obs_rdata, ev);
      end
      total++;
      if (obs_zero_bad || obs_addr_bad) begin bad++; $display("FAIL rnd%0d zero/addr got=%b%b want=00", k, obs_zero_bad, obs_addr_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
